// File: rtl/filtro_nivel_temperatura_if.sv
// Handshake bundle between the comparator/host side and the level filter.
// The host drives the sample strobe, level code and acknowledge; the filter returns the debounced status.
interface filtro_nivel_temperatura_if;
  logic       amostra;
  logic [1:0] nivel;
  logic       reconhece;
  logic [1:0] nivel_estavel;
  logic       mudou;
  logic       pendente;
  logic       alarme;

  modport master (
    output amostra, nivel, reconhece,
    input  nivel_estavel, mudou, pendente, alarme
  );

  modport slave (
    input  amostra, nivel, reconhece,
    output nivel_estavel, mudou, pendente, alarme
  );
endinterface

// File: rtl/filtro_nivel_temperatura.sv
// Debounces the 2-bit temperature level code and raises a latched over-temperature alarm
// once the stable level has stayed at 11 for ALARM_SAMPLES strobes.
module filtro_nivel_temperatura #(
  parameter int N_CONFIRM     = 4,
  parameter int ALARM_SAMPLES = 8
) (
  input logic                         clock,
  input logic                         reset,
  filtro_nivel_temperatura_if.slave   bus
);

  localparam logic [3:0] NCONF   = N_CONFIRM[3:0];
  localparam logic [7:0] NALARM  = ALARM_SAMPLES[7:0];
  localparam logic [1:0] NIVEL_QUENTE = 2'b11;

  localparam logic [1:0] OCIOSO      = 2'd0;
  localparam logic [1:0] CONTANDO    = 2'd1;
  localparam logic [1:0] ALARME      = 2'd2;
  localparam logic [1:0] RECONHECIDO = 2'd3;

  logic [1:0] estavel_q, estavel_d;
  logic [1:0] cand_q, cand_d;
  logic [3:0] cnt_q, cnt_d;
  logic       mudou_q, mudou_d;
  logic [7:0] acnt_q, acnt_d;
  logic [1:0] estado_q, estado_d;
  logic       quente;

  assign quente = (estavel_q == NIVEL_QUENTE);

  always_comb begin
    estavel_d = estavel_q;
    cand_d    = cand_q;
    cnt_d     = cnt_q;
    mudou_d   = 1'b0;
    if (bus.amostra) begin
      if (bus.nivel == estavel_q) begin
        cand_d = bus.nivel;
        cnt_d  = 4'd0;
      end else if ((bus.nivel == cand_q) && (cnt_q != 4'd0)) begin
        if ((cnt_q + 4'd1) == NCONF) begin
          estavel_d = bus.nivel;
          cnt_d     = 4'd0;
          mudou_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end else begin
        cand_d = bus.nivel;
        // A single-sample confirmation commits on the very first differing strobe.
        if (NCONF == 4'd1) begin
          estavel_d = bus.nivel;
          cnt_d     = 4'd0;
          mudou_d   = 1'b1;
        end else begin
          cnt_d = 4'd1;
        end
      end
    end
  end

  // Alarm FSM looks only at the registered stable level, never at the raw input.
  always_comb begin
    estado_d = estado_q;
    acnt_d   = acnt_q;
    case (estado_q)
      OCIOSO: begin
        if (quente) begin
          estado_d = CONTANDO;
          acnt_d   = 8'd0;
        end
      end
      CONTANDO: begin
        if (!quente) begin
          estado_d = OCIOSO;
        end else if (bus.amostra) begin
          acnt_d = acnt_q + 8'd1;
          if ((acnt_q + 8'd1) == NALARM) estado_d = ALARME;
        end
      end
      ALARME: begin
        if (bus.reconhece) estado_d = quente ? RECONHECIDO : OCIOSO;
      end
      RECONHECIDO: begin
        if (!quente) estado_d = OCIOSO;
      end
      default: estado_d = OCIOSO;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estavel_q <= 2'b00;
      cand_q    <= 2'b00;
      cnt_q     <= 4'd0;
      mudou_q   <= 1'b0;
      acnt_q    <= 8'd0;
      estado_q  <= OCIOSO;
    end else begin
      estavel_q <= estavel_d;
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      mudou_q   <= mudou_d;
      acnt_q    <= acnt_d;
      estado_q  <= estado_d;
    end
  end

  assign bus.nivel_estavel = estavel_q;
  assign bus.mudou         = mudou_q;
  assign bus.pendente      = (cnt_q != 4'd0);
  assign bus.alarme        = (estado_q == ALARME);

endmodule

// File: tb/tb_filtro_nivel_temperatura.sv
// Randomized and directed bench for the temperature level filter with a behavioural reference.
module tb_filtro_nivel_temperatura;
  localparam int NC = 4;
  localparam int NA = 8;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  filtro_nivel_temperatura_if bus ();

  filtro_nivel_temperatura #(.N_CONFIRM(NC), .ALARM_SAMPLES(NA)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference: stable level, pending level with its run length, and an alarm described as
  // "armed / hot-strobe tally / latched / acknowledged" flags.
  int m_stable, m_pend_lvl, m_run, m_hot_tally;
  bit m_pulse, m_armed, m_latched, m_acked;

  function automatic void model_reset();
    m_stable = 0; m_pend_lvl = 0; m_run = 0; m_hot_tally = 0;
    m_pulse = 0; m_armed = 0; m_latched = 0; m_acked = 0;
  endfunction

  function automatic void model_clk(input bit rst, input bit a, input int n, input bit rc);
    bit hot;
    if (rst) begin
      model_reset();
      return;
    end
    hot = (m_stable == 3);
    if (m_latched) begin
      if (rc) begin
        m_latched = 0;
        m_acked = hot;
      end
    end else if (m_acked) begin
      if (!hot) m_acked = 0;
    end else if (m_armed) begin
      if (!hot) m_armed = 0;
      else if (a) begin
        m_hot_tally++;
        if (m_hot_tally == NA) begin m_latched = 1; m_armed = 0; end
      end
    end else if (hot) begin
      m_armed = 1;
      m_hot_tally = 0;
    end
    m_pulse = 0;
    if (a) begin
      if (n == m_stable) begin
        m_run = 0; m_pend_lvl = n;
      end else begin
        if (n == m_pend_lvl && m_run > 0) m_run++;
        else begin m_pend_lvl = n; m_run = 1; end
        if (m_run == NC) begin m_stable = n; m_run = 0; m_pulse = 1; end
      end
    end
  endfunction

  function automatic logic [4:0] model_vec();
    logic [1:0] s;
    s = 2'(m_stable);
    return {s, m_pulse, (m_run != 0), m_latched};
  endfunction

  function automatic logic [4:0] dut_vec();
    return {bus.nivel_estavel, bus.mudou, bus.pendente, bus.alarme};
  endfunction

  task automatic step(input bit rst, input bit a, input logic [1:0] n, input bit rc);
    reset         = rst;
    bus.amostra   = a;
    bus.nivel     = n;
    bus.reconhece = rc;
    @(posedge clock);
    model_clk(rst, a, int'(n), rc);
    #1;
    reset = 1'b0; bus.amostra = 1'b0; bus.reconhece = 1'b0;
  endtask

  task automatic strobes(input logic [1:0] n, input int k);
    for (int i = 0; i < k; i++) step(0, 1, n, 0);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++)
      step(1, 1'($urandom), 2'($urandom), 1'($urandom));
    n_cmp++;
    if (dut_vec() !== 5'b00000) begin
      n_err++; $display("FAIL reset_state got %b exp %b", dut_vec(), 5'b00000);
    end
  endtask

  task automatic test_commit_abandon();
    strobes(2'b01, 3);
    n_cmp++;
    if (bus.nivel_estavel !== 2'b00 || bus.pendente !== 1'b1) begin
      n_err++; $display("FAIL commit_before est %b pend %b exp 00/1", bus.nivel_estavel, bus.pendente);
    end
    strobes(2'b01, 1);
    n_cmp++;
    if (bus.nivel_estavel !== 2'b01 || bus.mudou !== 1'b1 || bus.pendente !== 1'b0) begin
      n_err++; $display("FAIL commit_edge got %b exp 01/1/0", dut_vec());
    end
    step(0, 0, 2'b00, 0);
    n_cmp++;
    if (bus.mudou !== 1'b0) begin
      n_err++; $display("FAIL commit_pulse_width mudou %b exp 0", bus.mudou);
    end
    strobes(2'b10, 3);
    n_cmp++;
    if (bus.pendente !== 1'b1 || bus.nivel_estavel !== 2'b01) begin
      n_err++; $display("FAIL abandon_pending got %b exp pend 1 est 01", dut_vec());
    end
    strobes(2'b01, 1);
    n_cmp++;
    if (dut_vec() !== {2'b01, 3'b000}) begin
      n_err++; $display("FAIL abandon_clear got %b exp %b", dut_vec(), {2'b01, 3'b000});
    end
  endtask

  task automatic test_glitch_restart();
    logic [1:0] seq [7];
    int pulses;
    seq = '{2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01};
    step(1, 0, 2'b00, 0);
    pulses = 0;
    for (int i = 0; i < 7; i++) begin
      step(0, 1, seq[i], 0);
      pulses += int'(bus.mudou);
      n_cmp++;
      if (bus.nivel_estavel !== ((i == 6) ? 2'b01 : 2'b00)) begin
        n_err++; $display("FAIL glitch_est strobe %0d got %b", i + 1, bus.nivel_estavel);
      end
    end
    step(0, 0, 2'b00, 0);
    pulses += int'(bus.mudou);
    n_cmp++;
    if (pulses != 1) begin
      n_err++; $display("FAIL glitch_pulses got %0d exp 1", pulses);
    end
  endtask

  task automatic raise_alarm(input string tag);
    strobes(2'b11, NC);
    step(0, 0, 2'b00, 0);
    step(0, 0, 2'b00, 0);
    strobes(2'b11, NA - 1);
    n_cmp++;
    if (bus.alarme !== 1'b0) begin
      n_err++; $display("FAIL %s early alarme %b exp 0", tag, bus.alarme);
    end
    strobes(2'b11, 1);
    n_cmp++;
    if (bus.alarme !== 1'b1) begin
      n_err++; $display("FAIL %s assert alarme %b exp 1", tag, bus.alarme);
    end
  endtask

  task automatic test_alarm_ack();
    raise_alarm("alarm_first");
    step(0, 0, 2'b00, 1);
    n_cmp++;
    if (bus.alarme !== 1'b0) begin
      n_err++; $display("FAIL ack_clear alarme %b exp 0", bus.alarme);
    end
    strobes(2'b11, NA + 2);
    n_cmp++;
    if (bus.alarme !== 1'b0 || bus.nivel_estavel !== 2'b11) begin
      n_err++; $display("FAIL ack_hold got %b exp est 11 alarme 0", dut_vec());
    end
    strobes(2'b10, NC);
    raise_alarm("alarm_rearm");
  endtask

  task automatic test_latched();
    strobes(2'b01, NC);
    step(0, 0, 2'b00, 0);
    n_cmp++;
    if (bus.alarme !== 1'b1 || bus.nivel_estavel !== 2'b01) begin
      n_err++; $display("FAIL latched_hold got %b exp est 01 alarme 1", dut_vec());
    end
    step(0, 0, 2'b00, 1);
    n_cmp++;
    if (bus.alarme !== 1'b0) begin
      n_err++; $display("FAIL latched_ack alarme %b exp 0", bus.alarme);
    end
    strobes(2'b01, NA + 2);
    n_cmp++;
    if (bus.alarme !== 1'b0) begin
      n_err++; $display("FAIL latched_idle alarme %b exp 0", bus.alarme);
    end
  endtask

  task automatic test_reset_mid();
    step(1, 0, 2'b00, 0);
    strobes(2'b01, 3);
    step(1, 1, 2'b01, 0);
    n_cmp++;
    if (bus.pendente !== 1'b0 || bus.nivel_estavel !== 2'b00) begin
      n_err++; $display("FAIL reset_mid got %b exp est 00 pend 0", dut_vec());
    end
    strobes(2'b01, 1);
    n_cmp++;
    if (bus.nivel_estavel !== 2'b00 || bus.pendente !== 1'b1) begin
      n_err++; $display("FAIL reset_mid_after got %b exp est 00 pend 1", dut_vec());
    end
    step(1, 0, 2'b00, 0);
    raise_alarm("alarm_pre_reset");
    step(1, 1, 2'b11, 0);
    n_cmp++;
    if (dut_vec() !== 5'b00000) begin
      n_err++; $display("FAIL reset_alarm got %b exp 00000", dut_vec());
    end
  endtask

  task automatic test_random();
    logic [1:0] n;
    for (int i = 0; i < 1500; i++) begin
      n = ($urandom_range(0, 9) < 6) ? 2'b11 : 2'($urandom);
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 2) != 0), n,
           ($urandom_range(0, 11) == 0));
      n_cmp++;
      if (dut_vec() !== model_vec()) begin
        n_err++; $display("FAIL random_step %0d got %b exp %b", i, dut_vec(), model_vec());
      end
    end
  endtask

  initial begin
    reset = 1'b1; bus.amostra = 1'b0; bus.nivel = 2'b00; bus.reconhece = 1'b0;
    model_reset();
    test_reset();
    test_commit_abandon();
    test_glitch_restart();
    test_alarm_ack();
    test_latched();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
